mem_bus_arbiter: RTL and testbench

- Shares the SOC's single-ported unified memory between the instruction-fetch requester and the data-access (MEM stage) requester.
- Serialises accesses through a 3-state FSM and holds each transfer until the memory answers.
- Aborts hung transfers with an error after a timeout.
- Drives per-requester stall signals that the pipeline controller uses to freeze the pipeline.

---
 rtl/mem_bus_arbiter_pkg.sv | 28 ++
 rtl/mem_bus_arbiter_bus_timeout_cnt.sv | 46 ++++
 rtl/mem_bus_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the unified-memory bus arbiter.
// Holds the FSM state encoding, the grant identifiers and the default bus widths
// used by mem_bus_arbiter and its timeout counter.
package mem_bus_arbiter_pkg;

  // Default bus geometry.
  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefDataW = 32;
  localparam int unsigned BeW      = 4;

  // Timeout counter width; wide enough for the largest legal timeout of 255.
  localparam int unsigned TmoCntW  = 8;

  // All byte lanes enabled; used for instruction fetches.
  localparam logic [BeW-1:0] BeAll = 4'hF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } arb_state_e;

  typedef enum logic {
    GntIf = 1'b0,
    GntDm = 1'b1
  } arb_gnt_e;

endpackage

// File: rtl/mem_bus_arbiter_bus_timeout_cnt.sv
// Transfer watchdog for the memory bus arbiter.
// Counts cycles while enabled and raises expired_o once the count reaches
// Timeout-1. Clear has priority over enable; the count holds at the limit.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_ni     asynchronous active-low reset
//   clr_i      synchronous clear of the count
//   en_i       count enable (one increment per cycle)
//   expired_o  count has reached Timeout-1
module bus_timeout_cnt #(
  parameter int unsigned Timeout = 16,
  parameter int unsigned CntW    = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CntW-1:0] CntLast = CntW'(Timeout - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      // Hold at the limit so the counter never wraps back to a live value.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one single-ported unified memory between the instruction
// fetch (IF) requester and the data-access (DM) requester.
// A three-state FSM (IDLE -> BUSY -> DONE) serialises transfers. DM normally
// wins, but after StarveLim consecutive DM grants with IF waiting, IF is forced
// through. A watchdog aborts transfers the memory never answers, returning
// rdata=0 with bus_err_o raised alongside the ack.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   if_req_i, if_addr_i                fetch request / address (held until ack)
//   if_rdata_o, if_ack_o, if_stall_o   fetched word, completion pulse, stall
//   dm_req_i, dm_we_i, dm_be_i,
//   dm_addr_i, dm_wdata_i              data request (held until ack)
//   dm_rdata_o, dm_ack_o, dm_stall_o   read data, completion pulse, stall
//   bus_err_o                          pulses with the ack of a timed-out transfer
//   ram_req_o, ram_we_o, ram_be_o,
//   ram_addr_o, ram_wdata_o            memory request, held for the transfer
//   ram_rdata_i, ram_ready_i           memory response
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned AddrW     = DefAddrW,
  parameter int unsigned DataW     = DefDataW,
  parameter int unsigned Timeout   = 16,
  parameter int unsigned StarveLim = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  // Instruction fetch port
  input  logic             if_req_i,
  input  logic [AddrW-1:0] if_addr_i,
  output logic [DataW-1:0] if_rdata_o,
  output logic             if_ack_o,
  output logic             if_stall_o,
  // Data access port
  input  logic             dm_req_i,
  input  logic             dm_we_i,
  input  logic [BeW-1:0]   dm_be_i,
  input  logic [AddrW-1:0] dm_addr_i,
  input  logic [DataW-1:0] dm_wdata_i,
  output logic [DataW-1:0] dm_rdata_o,
  output logic             dm_ack_o,
  output logic             dm_stall_o,
  output logic             bus_err_o,
  // Memory port
  output logic             ram_req_o,
  output logic             ram_we_o,
  output logic [BeW-1:0]   ram_be_o,
  output logic [AddrW-1:0] ram_addr_o,
  output logic [DataW-1:0] ram_wdata_o,
  input  logic [DataW-1:0] ram_rdata_i,
  input  logic             ram_ready_i
);

  localparam int unsigned StarveW = $clog2(StarveLim + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(StarveLim);

  arb_state_e state_q, state_d;

  // Latched transfer, captured at the arbitration edge.
  arb_gnt_e         gnt_q, gnt_d;
  logic             we_q, we_d;
  logic [BeW-1:0]   be_q, be_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [DataW-1:0] wdata_q, wdata_d;
  logic             err_q, err_d;

  logic [DataW-1:0]   if_rdata_q, if_rdata_d;
  logic [DataW-1:0]   dm_rdata_q, dm_rdata_d;
  logic [StarveW-1:0] starve_q, starve_d;

  logic any_req;
  logic if_forced;
  logic dm_wins;
  logic arb_fire;
  logic tmo_expired;

  assign any_req   = if_req_i | dm_req_i;
  // IF overrides DM only once DM has been granted StarveLim times in a row
  // while IF was waiting.
  assign if_forced = (starve_q == StarveMax) && if_req_i;
  assign dm_wins   = dm_req_i && !if_forced;
  assign arb_fire  = (state_q == StIdle) && any_req;

  bus_timeout_cnt #(
    .Timeout (Timeout),
    .CntW    (TmoCntW)
  ) u_tmo_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (state_q != StBusy),
    .en_i      (state_q == StBusy),
    .expired_o (tmo_expired)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        // Live requests are ignored here, so a requester dropping its req
        // early cannot wedge the FSM.
        if (ram_ready_i || tmo_expired) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if_ack_o    = 1'b0;
    dm_ack_o    = 1'b0;
    bus_err_o   = 1'b0;
    unique case (state_q)
      StBusy: begin
        ram_req_o   = 1'b1;
        ram_we_o    = we_q;
        ram_be_o    = be_q;
        ram_addr_o  = addr_q;
        ram_wdata_o = wdata_q;
      end
      StDone: begin
        if_ack_o  = (gnt_q == GntIf);
        dm_ack_o  = (gnt_q == GntDm);
        bus_err_o = err_q;
      end
      default: begin
      end
    endcase
  end

  assign if_stall_o = if_req_i & ~if_ack_o;
  assign dm_stall_o = dm_req_i & ~dm_ack_o;
  assign if_rdata_o = if_rdata_q;
  assign dm_rdata_o = dm_rdata_q;

  // ---------------------------------------------------------------------------
  // Datapath: latched request, read data, error flag and starvation counter
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_d      = gnt_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    starve_d   = starve_q;

    if (arb_fire) begin
      err_d = 1'b0;
      if (dm_wins) begin
        gnt_d   = GntDm;
        we_d    = dm_we_i;
        be_d    = dm_be_i;
        addr_d  = dm_addr_i;
        wdata_d = dm_wdata_i;
        if (if_req_i && (starve_q != StarveMax)) begin
          starve_d = starve_q + 1'b1;
        end
      end else begin
        gnt_d    = GntIf;
        we_d     = 1'b0;
        be_d     = BeAll;
        addr_d   = if_addr_i;
        wdata_d  = '0;
        starve_d = '0;
      end
    end

    if (state_q == StBusy) begin
      // A response arriving in the timeout cycle still counts as success.
      if (ram_ready_i) begin
        if (gnt_q == GntIf) begin
          if_rdata_d = ram_rdata_i;
        end else begin
          dm_rdata_d = ram_rdata_i;
        end
      end else if (tmo_expired) begin
        err_d = 1'b1;
        if (gnt_q == GntIf) begin
          if_rdata_d = '0;
        end else begin
          dm_rdata_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_q      <= GntIf;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      starve_q   <= '0;
    end else begin
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      starve_q   <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a wait-state memory model and an
// ack scoreboard: each request pushes its expected owner/rdata/err, and the
// ack monitor pops and compares when an ack appears.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        dm_stall;
  logic        bus_err;
  logic        ram_req;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_dm;
    logic [31:0] rdata;
    bit          err;
  } exp_t;
  exp_t sb[$];

  // Memory model: ready after wait_states BUSY cycles, never if mem_hang.
  int          wait_states = 0;
  bit          mem_hang    = 1'b0;
  logic [31:0] mem_salt    = 32'h0;
  int          wcnt        = 0;

  assign ram_rdata = mem_salt ^ ram_addr;
  assign ram_ready = ram_req && !mem_hang && (wcnt >= wait_states);

  always @(posedge clk) begin
    if (!ram_req) wcnt <= 0;
    else          wcnt <= wcnt + 1;
  end

  mem_bus_arbiter #(
    .AddrW     (32),
    .DataW     (32),
    .Timeout   (16),
    .StarveLim (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_rdata_o  (if_rdata),
    .if_ack_o    (if_ack),
    .if_stall_o  (if_stall),
    .dm_req_i    (dm_req),
    .dm_we_i     (dm_we),
    .dm_be_i     (dm_be),
    .dm_addr_i   (dm_addr),
    .dm_wdata_i  (dm_wdata),
    .dm_rdata_o  (dm_rdata),
    .dm_ack_o    (dm_ack),
    .dm_stall_o  (dm_stall),
    .bus_err_o   (bus_err),
    .ram_req_o   (ram_req),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .ram_ready_i (ram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit is_dm, input logic [31:0] rdata, input bit err);
    exp_t e;
    e.is_dm = is_dm;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input bit is_dm, input int bound);
    int n = 0;
    while (!(is_dm ? dm_ack : if_ack) && n < bound) begin
      step();
      n++;
    end
    check(is_dm ? "dm_ack_seen" : "if_ack_seen", 64'(is_dm ? dm_ack : if_ack), 64'd1);
  endtask

  task automatic wait_ram_req(input int bound);
    int n = 0;
    while (!ram_req && n < bound) begin
      step();
      n++;
    end
    check("ram_req_seen", 64'(ram_req), 64'd1);
  endtask

  // Ack monitor: exclusivity every cycle, scoreboard compare on each ack.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    check("ack_exclusive", 64'(if_ack & dm_ack), 64'd0);
    if (if_ack || dm_ack) begin
      check("sb_pending", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ack_owner", 64'(dm_ack), 64'(e.is_dm));
        check("ack_rdata", 64'(e.is_dm ? dm_rdata : if_rdata), 64'(e.rdata));
        check("ack_bus_err", 64'(bus_err), 64'(e.err));
      end
    end
  end

  initial begin
    bit   exp_dm[7];
    int   n;

    rst_n    = 1'b0;
    if_req   = 1'b1;
    if_addr  = 32'h0000_0040;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_be    = 4'h0;
    dm_addr  = 32'h0;
    dm_wdata = 32'h0;

    // Reset with IF already requesting.
    step();
    step();
    check("rst_ram_req", 64'(ram_req), 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_acks", 64'({if_ack, dm_ack}), 64'd0);
    check("rst_bus_err", 64'(bus_err), 64'd0);
    check("rst_if_rdata", 64'(if_rdata), 64'd0);
    check("rst_dm_rdata", 64'(dm_rdata), 64'd0);
    check("rst_if_stall", 64'(if_stall), 64'd1);

    // Zero-wait fetch.
    wait_states = 0;
    mem_salt    = 32'h2408_0005 ^ 32'h0000_0040;
    push_exp(1'b0, 32'h2408_0005, 1'b0);
    rst_n = 1'b1;
    check("rel_ram_req", 64'(ram_req), 64'd0);
    step();
    check("fetch_ram_req", 64'(ram_req), 64'd1);
    check("fetch_ram_addr", 64'(ram_addr), 64'h40);
    check("fetch_ram_be", 64'({ram_we, ram_be}), 64'h0F);
    check("fetch_stall_busy", 64'(if_stall), 64'd1);
    step();
    check("fetch_ack", 64'(if_ack), 64'd1);
    check("fetch_ack_ram_req", 64'(ram_req), 64'd0);
    check("fetch_stall_ack", 64'(if_stall), 64'd0);
    if_req = 1'b0;
    step();
    check("fetch_idle_ack", 64'(if_ack), 64'd0);
    check("fetch_idle_ram_req", 64'(ram_req), 64'd0);
    check("if_rdata_hold", 64'(if_rdata), 64'h2408_0005);

    // Simultaneous IF and DM: DM first, then IF.
    mem_salt = 32'h1111_2222;
    if_req   = 1'b1;
    if_addr  = 32'h0000_0080;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_be    = 4'b0011;
    dm_addr  = 32'h0000_0100;
    dm_wdata = 32'hDEAD_BEEF;
    push_exp(1'b1, 32'h1111_2222 ^ 32'h100, 1'b0);
    push_exp(1'b0, 32'h1111_2222 ^ 32'h80, 1'b0);
    step();
    check("sim_ram_addr", 64'(ram_addr), 64'h100);
    check("sim_ram_we_be", 64'({ram_we, ram_be}), 64'h13);
    check("sim_ram_wdata", 64'(ram_wdata), 64'hDEAD_BEEF);
    check("sim_stalls", 64'({if_stall, dm_stall}), 64'h3);
    step();
    check("sim_dm_ack", 64'(dm_ack), 64'd1);
    dm_req = 1'b0;
    dm_we  = 1'b0;
    step();
    check("sim_idle_ram_req", 64'(ram_req), 64'd0);
    step();
    check("sim_if_ram_addr", 64'(ram_addr), 64'h80);
    check("sim_if_we_be", 64'({ram_we, ram_be}), 64'h0F);
    wait_ack(1'b0, 10);
    if_req = 1'b0;

    // Starvation: DM and IF held; grants must be DM x4, IF, DM, then IF.
    wait_states = 1;
    mem_salt    = 32'h5A5A_0000;
    if_addr     = 32'h0000_0200;
    dm_addr     = 32'h0000_0300;
    dm_we       = 1'b0;
    exp_dm      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int g = 0; g < 7; g++) begin
      push_exp(exp_dm[g], mem_salt ^ (exp_dm[g] ? dm_addr : if_addr), 1'b0);
    end
    step();
    if_req = 1'b1;
    dm_req = 1'b1;
    for (int g = 0; g < 7; g++) begin
      wait_ram_req(10);
      check("starve_grant_addr", 64'(ram_addr), 64'(exp_dm[g] ? dm_addr : if_addr));
      wait_ack(exp_dm[g], 10);
      if (g == 5) dm_req = 1'b0;
      if (g == 6) if_req = 1'b0;
    end

    // Timeout: DM read against a hung memory.
    step();
    mem_hang = 1'b1;
    dm_addr  = 32'h0000_0400;
    dm_req   = 1'b1;
    push_exp(1'b1, 32'h0, 1'b1);
    step();
    n = 0;
    while (ram_req && n < 40) begin
      n++;
      step();
    end
    check("tmo_busy_cycles", 64'(n), 64'd16);
    check("tmo_dm_ack", 64'(dm_ack), 64'd1);
    check("tmo_bus_err", 64'(bus_err), 64'd1);
    dm_req   = 1'b0;
    mem_hang = 1'b0;
    step();
    check("tmo_idle", 64'({ram_req, dm_ack, bus_err}), 64'd0);
    check("tmo_rdata_hold", 64'(dm_rdata), 64'd0);

    // Ready in the timeout cycle itself: success wins.
    wait_states = 15;
    mem_salt    = 32'h0BAD_F00D;
    dm_addr     = 32'h0000_0440;
    dm_req      = 1'b1;
    push_exp(1'b1, 32'h0BAD_F00D ^ 32'h440, 1'b0);
    wait_ack(1'b1, 40);
    check("prec_bus_err", 64'(bus_err), 64'd0);
    dm_req = 1'b0;
    step();

    // Reset during BUSY: transfer abandoned, no ack afterwards.
    wait_states = 3;
    dm_addr     = 32'h0000_0500;
    dm_req      = 1'b1;
    step();
    check("mrst_busy", 64'(ram_req), 64'd1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_ram_req_async", 64'(ram_req), 64'd0);
    check("mrst_dm_rdata", 64'(dm_rdata), 64'd0);
    dm_req = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mrst_no_ack", 64'({if_ack, dm_ack, ram_req}), 64'd0);
    end

    // Normal fetch after the aborted transfer.
    wait_states = 0;
    mem_salt    = 32'h7777_0000;
    if_addr     = 32'h0000_0600;
    if_req      = 1'b1;
    push_exp(1'b0, 32'h7777_0000 ^ 32'h600, 1'b0);
    wait_ram_req(10);
    check("post_rst_addr", 64'(ram_addr), 64'h600);
    wait_ack(1'b0, 10);
    if_req = 1'b0;
    step();
    step();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
